// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state codes,
// forwarding-select codes and the packed bundle of pipeline-register controls.
package hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_clr;
    logic idex_clr;
    logic exmem_clr;
  } ctrl_t;

  // Free-running pipeline: every register advances and nothing is flushed.
  localparam ctrl_t CTRL_RUN = 8'b11111_000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register indices and
// flags in, stall/flush/forwarding controls and the stall counter out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              ex_reg_write, ex_is_load;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic              ex_mc_start, ex_branch_taken;

  logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic              ifid_clr, idex_clr, exmem_clr;
  logic [1:0]        fwd_a, fwd_b;
  logic              mc_busy, mc_done;
  logic [PERF_W-1:0] perf_stall;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_mc_start, ex_branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, fwd_a, fwd_b, mc_busy, mc_done, perf_stall
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_mc_start, ex_branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, fwd_a, fwd_b, mc_busy, mc_done, perf_stall
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand bypass select for one EX source register; the younger MEM result
// wins over WB, and x0 is never forwarded.
module fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  always_comb begin
    // NOTE: assign a default first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush,
// multi-cycle EX occupancy, operand forwarding and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  logic [0:0]        state, state_nxt;
  logic [CNT_W-1:0]  mc_cnt, cnt_nxt;
  logic [PERF_W-1:0] perf_q;
  logic              load_use;
  ctrl_t             ctrl;

  assign load_use = bus.ex_is_load && bus.ex_reg_write && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;
    cnt_nxt   = mc_cnt;
    if (state == ST_MC_BUSY) begin
      // Pipeline events are ignored here; only the countdown matters.
      if (mc_cnt == '0) begin
        state_nxt = ST_RUN;
      end else begin
        ctrl.pc_en     = 1'b0;
        ctrl.ifid_en   = 1'b0;
        ctrl.idex_en   = 1'b0;
        ctrl.exmem_clr = 1'b1;
        cnt_nxt        = mc_cnt - CNT_W'(1);
      end
    end else if (bus.ex_branch_taken) begin
      // Redirect flushes the wrong-path instructions and beats any stall.
      ctrl.ifid_clr = 1'b1;
      ctrl.idex_clr = 1'b1;
    end else if (bus.ex_mc_start) begin
      ctrl.pc_en     = 1'b0;
      ctrl.ifid_en   = 1'b0;
      ctrl.idex_en   = 1'b0;
      ctrl.exmem_clr = 1'b1;
      state_nxt      = ST_MC_BUSY;
      cnt_nxt        = CNT_INIT;
    end else if (load_use) begin
      ctrl.pc_en    = 1'b0;
      ctrl.ifid_en  = 1'b0;
      ctrl.idex_clr = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      mc_cnt <= '0;
      perf_q <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= cnt_nxt;
      if (!ctrl.pc_en) perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.ifid_en    = ctrl.ifid_en;
  assign bus.idex_en    = ctrl.idex_en;
  assign bus.exmem_en   = ctrl.exmem_en;
  assign bus.memwb_en   = ctrl.memwb_en;
  assign bus.ifid_clr   = ctrl.ifid_clr;
  assign bus.idex_clr   = ctrl.idex_clr;
  assign bus.exmem_clr  = ctrl.exmem_clr;
  assign bus.mc_busy    = (state == ST_MC_BUSY);
  assign bus.mc_done    = (state == ST_MC_BUSY) && (mc_cnt == '0);
  assign bus.perf_stall = perf_q;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(bus.ex_rs1), .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write),
    .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .sel(bus.fwd_a)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(bus.ex_rs2), .mem_rd(bus.mem_rd), .mem_reg_write(bus.mem_reg_write),
    .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .sel(bus.fwd_b)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LAT, default 4: total EX occupancy in cycles of a multi-cycle op (legal 2..16).
REQ-002 SHALL have parameter REG_AW, default 5: register-index width.
REQ-003 SHALL have parameter PERF_W, default 32: stall-counter width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_rs1, id_rs2  in  REG_AW each  source registers of the ID-stage instruction.
REQ-007 ex_rs1, ex_rs2  in  REG_AW each  source registers of the EX-stage instruction.
REQ-008 ex_rd, ex_reg_write, ex_is_load  in  REG_AW/1/1  EX destination, write-enable, load flag.
REQ-009 mem_rd, mem_reg_write  in  REG_AW/1  MEM-stage destination and write-enable.
REQ-010 wb_rd, wb_reg_write  in  REG_AW/1  WB-stage destination and write-enable.
REQ-011 ex_mc_start  in  1  multi-cycle op present in EX this cycle.
REQ-012 ex_branch_taken  in  1  EX resolved a redirect this cycle.
REQ-013 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  enables for the PC and the four pipeline registers.
REQ-014 ifid_clr, idex_clr, exmem_clr  out  1 each  synchronous clears for the corresponding pipeline registers.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-016 mc_busy, mc_done  out  1 each  multi-cycle op in progress; final-cycle pulse.
REQ-017 perf_stall  out  PERF_W  cycles in which pc_en was 0.

Function
REQ-018 SHALL implement FSM states RUN and MC_BUSY plus a down-counter mc_cnt of width clog2(MC_LAT).
REQ-019 Default (RUN, no event): all *_en=1, all *_clr=0.
REQ-020 Load-use: RUN & ex_is_load & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) SHALL, in that same cycle, drive pc_en=0, ifid_en=0, idex_clr=1.
REQ-021 Redirect: RUN & ex_branch_taken SHALL drive ifid_clr=1 and idex_clr=1 with pc_en=1; redirect overrides load-use, so pc_en and ifid_en stay 1.
REQ-022 RUN & ex_mc_start & !ex_branch_taken SHALL drive pc_en=ifid_en=idex_en=0 and exmem_clr=1, then next state MC_BUSY with mc_cnt=MC_LAT-2.
REQ-023 In MC_BUSY: pc_en=ifid_en=idex_en=0, exmem_clr=1, memwb_en=1, mc_busy=1; mc_cnt decrements each cycle.
REQ-024 In MC_BUSY with mc_cnt==0: mc_done=1, all enables=1, exmem_clr=0 (result enters EX/MEM); next state RUN.
REQ-025 Total EX occupancy of a multi-cycle op SHALL be exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
REQ-026 In MC_BUSY, ex_branch_taken, ex_mc_start and the load-use condition SHALL be ignored.
REQ-027 fwd_a SHALL be 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1; else 00. MEM has priority over WB.
REQ-028 fwd_b SHALL follow the REQ-027 rules using ex_rs2.
REQ-029 fwd_a and fwd_b SHALL be combinational and independent of FSM state.
REQ-030 perf_stall SHALL increment on each clock edge where pc_en was 0, and wrap modulo 2^PERF_W.

Reset
REQ-031 While rst_n=0: state=RUN, mc_cnt=0, perf_stall=0, mc_busy=0, mc_done=0.
REQ-032 rst_n falling mid-MC_BUSY SHALL abort the op immediately and return to RUN; the first post-reset edge SHALL start from RUN behaviour.

Structure
REQ-033 Forwarding encodings (FWD_RF/FWD_WB/FWD_MEM) and the state encoding SHALL live in the shared pipeline package.
REQ-034 Forwarding selection SHALL be a sub-module fwd_unit, instantiated once per operand.

Verification
REQ-035 lw x5 in EX, ID reads x5: pc_en=0, ifid_en=0, idex_clr=1 for exactly 1 cycle; perf_stall +1.
REQ-036 Load-use on x5 with ex_branch_taken=1 in the same cycle: pc_en=1, ifid_clr=1, idex_clr=1, no stall.
REQ-037 ex_mc_start with MC_LAT=4: pc_en=0 for 3 cycles, mc_done on the 4th cycle, then RUN; perf_stall +3.
REQ-038 mem_rd=wb_rd=7, ex_rs1=7: fwd_a=10. With mem_rd=0 and wb_rd=0: fwd_a=00.
REQ-039 rst_n pulsed low on the 2nd MC_BUSY cycle: mc_busy=0 and perf_stall=0 immediately; all enables=1 after release.
REQ-040 Preload perf_stall to 2^PERF_W-1, then one stall cycle: perf_stall wraps to 0.
